// File: rtl/lpddr2_pkg.sv
// rtl/lpddr2_pkg.sv - shared types and constants for the LPDDR2 request responder
package lpddr2_pkg;

   localparam int          LPDDR2_ADDR_W   = 27;
   localparam int          LPDDR2_DATA_W   = 32;
   localparam logic [31:0] LPDDR2_ERR_DATA = 32'hDEAD_BEEF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_CMD,
      ST_RD_WAIT,
      ST_WR_CMD,
      ST_ACK,
      ST_RELEASE
   } lpddr2_resp_state_t;

endpackage

// File: rtl/req_timeout_counter.sv
// rtl/req_timeout_counter.sv - saturating cycle counter with clear and limit detect
module req_timeout_counter #(
   parameter int MAX = 1024,
   localparam int W  = $clog2(MAX + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam logic [W-1:0] LIMIT = W'(MAX);
   localparam logic [W-1:0] LAST  = W'(MAX - 1);

   logic [W-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && count != LIMIT) begin
         count <= count + 1'b1;
      end
   end

   // Asserted on the edge at which the count reaches the limit.
   assign expire = enable && (count >= LAST);

endmodule

// File: rtl/lpddr2_req_responder.sv
// rtl/lpddr2_req_responder.sv - CPU level-request to single-beat Avalon-MM responder
module lpddr2_req_responder
   import lpddr2_pkg::*;
#(
   parameter int                ADDR_W         = LPDDR2_ADDR_W,
   parameter int                DATA_W         = LPDDR2_DATA_W,
   parameter int                TIMEOUT_CYCLES = 1024,
   parameter logic [DATA_W-1:0] ERR_DATA       = DATA_W'(LPDDR2_ERR_DATA)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [ADDR_W-1:0]   req_address,
   input  logic [DATA_W-1:0]   req_write_data,
   input  logic                req_rreq,
   input  logic                req_wreq,
   output logic [DATA_W-1:0]   req_read_data,
   output logic                req_ack,
   output logic                req_busy,
   input  logic                init_done,
   output logic [ADDR_W-1:0]   avl_address,
   output logic                avl_read,
   output logic                avl_write,
   output logic [DATA_W-1:0]   avl_writedata,
   output logic [DATA_W/8-1:0] avl_byteenable,
   output logic [2:0]          avl_burstcount,
   input  logic                avl_waitrequest,
   input  logic [DATA_W-1:0]   avl_readdata,
   input  logic                avl_readdatavalid,
   output logic                timeout_err,
   output logic                conflict_err
);

   lpddr2_resp_state_t state, state_nxt;

   logic cap_rd, cap_wr, load_rdata, load_err, set_tmo, set_conflict;
   logic tmo_run, tmo_expire;

   assign tmo_run = (state == ST_RD_CMD) || (state == ST_RD_WAIT) || (state == ST_WR_CMD);

   req_timeout_counter #(
      .MAX (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk    (clk),
      .rst    (rst),
      .clear  (!tmo_run),
      .enable (tmo_run),
      .expire (tmo_expire)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      cap_rd       = 1'b0;
      cap_wr       = 1'b0;
      load_rdata   = 1'b0;
      load_err     = 1'b0;
      set_tmo      = 1'b0;
      set_conflict = 1'b0;
      case (state)
         ST_IDLE: begin
            if (init_done) begin
               if (req_wreq) begin
                  cap_wr       = 1'b1;
                  set_conflict = req_rreq;
                  state_nxt    = ST_WR_CMD;
               end else if (req_rreq) begin
                  cap_rd    = 1'b1;
                  state_nxt = ST_RD_CMD;
               end
            end
         end
         ST_RD_CMD: begin
            // Real data on the accepting edge beats a simultaneous timeout.
            if (!avl_waitrequest && avl_readdatavalid) begin
               load_rdata = 1'b1;
               state_nxt  = ST_ACK;
            end else if (tmo_expire) begin
               load_err  = 1'b1;
               set_tmo   = 1'b1;
               state_nxt = ST_ACK;
            end else if (!avl_waitrequest) begin
               state_nxt = ST_RD_WAIT;
            end
         end
         ST_RD_WAIT: begin
            if (avl_readdatavalid) begin
               load_rdata = 1'b1;
               state_nxt  = ST_ACK;
            end else if (tmo_expire) begin
               load_err  = 1'b1;
               set_tmo   = 1'b1;
               state_nxt = ST_ACK;
            end
         end
         ST_WR_CMD: begin
            if (!avl_waitrequest) begin
               state_nxt = ST_ACK;
            end else if (tmo_expire) begin
               set_tmo   = 1'b1;
               state_nxt = ST_ACK;
            end
         end
         ST_ACK: begin
            state_nxt = ST_RELEASE;
         end
         ST_RELEASE: begin
            // Held level requests must drop before another one is taken.
            if (!req_rreq && !req_wreq) begin
               state_nxt = ST_IDLE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         avl_address   <= '0;
         avl_writedata <= '0;
         req_read_data <= '0;
         timeout_err   <= 1'b0;
         conflict_err  <= 1'b0;
      end else begin
         if (cap_rd || cap_wr) begin
            avl_address <= req_address;
         end
         if (cap_wr) begin
            avl_writedata <= req_write_data;
         end
         if (load_rdata) begin
            req_read_data <= avl_readdata;
         end else if (load_err) begin
            req_read_data <= ERR_DATA;
         end
         if (set_tmo) begin
            timeout_err <= 1'b1;
         end
         if (set_conflict) begin
            conflict_err <= 1'b1;
         end
      end
   end

   assign avl_read       = (state == ST_RD_CMD);
   assign avl_write      = (state == ST_WR_CMD);
   assign req_ack        = (state == ST_ACK);
   assign req_busy       = (state != ST_IDLE);
   assign avl_byteenable = '1;
   assign avl_burstcount = 3'd1;

endmodule

// File: tb/tb_lpddr2_req_responder.sv
// tb/tb_lpddr2_req_responder.sv - self-checking bench for lpddr2_req_responder
module tb_lpddr2_req_responder;

   localparam int AW  = 27;
   localparam int DW  = 32;
   localparam int TMO = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [AW-1:0] req_address = '0;
   logic [DW-1:0] req_write_data = '0;
   logic          req_rreq = 1'b0;
   logic          req_wreq = 1'b0;
   logic [DW-1:0] req_read_data;
   logic          req_ack;
   logic          req_busy;
   logic          init_done = 1'b0;
   logic [AW-1:0] avl_address;
   logic          avl_read;
   logic          avl_write;
   logic [DW-1:0] avl_writedata;
   logic [3:0]    avl_byteenable;
   logic [2:0]    avl_burstcount;
   logic          avl_waitrequest = 1'b1;
   logic [DW-1:0] avl_readdata = 32'h5555_AAAA;
   logic          avl_readdatavalid = 1'b0;
   logic          timeout_err;
   logic          conflict_err;

   always #5 clk = ~clk;

   lpddr2_req_responder #(
      .ADDR_W         (AW),
      .DATA_W         (DW),
      .TIMEOUT_CYCLES (TMO),
      .ERR_DATA       (32'hDEAD_BEEF)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .req_address       (req_address),
      .req_write_data    (req_write_data),
      .req_rreq          (req_rreq),
      .req_wreq          (req_wreq),
      .req_read_data     (req_read_data),
      .req_ack           (req_ack),
      .req_busy          (req_busy),
      .init_done         (init_done),
      .avl_address       (avl_address),
      .avl_read          (avl_read),
      .avl_write         (avl_write),
      .avl_writedata     (avl_writedata),
      .avl_byteenable    (avl_byteenable),
      .avl_burstcount    (avl_burstcount),
      .avl_waitrequest   (avl_waitrequest),
      .avl_readdata      (avl_readdata),
      .avl_readdatavalid (avl_readdatavalid),
      .timeout_err       (timeout_err),
      .conflict_err      (conflict_err)
   );

   typedef struct {
      bit          rd;
      bit          wr;
      logic [26:0] addr;
      logic [31:0] wdata;
      int          wait_n;
      int          rdv_dly;
      logic [31:0] rdata;
      int          exp_ack;
      int          exp_strobe;
      bit          exp_accept;
      logic [31:0] exp_rdata;
      int          hold;
      bit          exp_conf;
      bit          exp_tmo;
   } vec_t;

   typedef struct {
      bit          wr;
      logic [26:0] addr;
      logic [31:0] data;
   } cmd_t;

   cmd_t exp_q[$];
   vec_t vecs[9];
   vec_t post_vec;
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input bit rd, input bit wr, input logic [26:0] a, input logic [31:0] wd,
                               input int wn, input int dly, input logic [31:0] rdat, input int ack,
                               input int strb, input bit acc, input logic [31:0] erd, input int hold,
                               input bit conf, input bit tmo);
      vec_t v;
      v.rd = rd; v.wr = wr; v.addr = a; v.wdata = wd; v.wait_n = wn; v.rdv_dly = dly;
      v.rdata = rdat; v.exp_ack = ack; v.exp_strobe = strb; v.exp_accept = acc;
      v.exp_rdata = erd; v.hold = hold; v.exp_conf = conf; v.exp_tmo = tmo;
      return v;
   endfunction

   // Acts as the Avalon slave for one transaction and scores the issued command.
   task automatic run_vec(input vec_t v, input string tag);
      int   cyc = 0;
      int   cmd_n = 0;
      int   strobes = 0;
      int   dly_left = -1;
      bit   done = 1'b0;
      bit   bad = 1'b0;
      cmd_t c;
      @(negedge clk);
      req_address    = v.addr;
      req_write_data = v.wdata;
      req_rreq       = v.rd;
      req_wreq       = v.wr;
      if (v.exp_accept) exp_q.push_back('{v.wr, v.addr, v.wr ? v.wdata : 32'h0});
      while (!done && cyc < 100) begin
         @(negedge clk);
         cyc++;
         avl_waitrequest   = 1'b1;
         avl_readdatavalid = 1'b0;
         avl_readdata      = 32'h5555_AAAA;
         if (req_ack) begin
            done = 1'b1;
         end else if (avl_read || avl_write) begin
            strobes++;
            if (avl_address !== v.addr) bad = 1'b1;
            if (cmd_n >= v.wait_n) begin
               avl_waitrequest = 1'b0;
               if (exp_q.size() != 0) begin
                  c = exp_q.pop_front();
                  check({tag, "_kind"}, avl_write, c.wr);
                  check({tag, "_addr"}, avl_address, c.addr);
                  if (c.wr) check({tag, "_wdata"}, avl_writedata, c.data);
               end else begin
                  check({tag, "_unexpected_cmd"}, 1, 0);
               end
               if (avl_read) begin
                  if (v.rdv_dly == 0) begin
                     avl_readdatavalid = 1'b1;
                     avl_readdata      = v.rdata;
                  end else begin
                     dly_left = v.rdv_dly;
                  end
               end
            end
            cmd_n++;
         end else if (dly_left > 0) begin
            dly_left--;
            if (dly_left == 0) begin
               avl_readdatavalid = 1'b1;
               avl_readdata      = v.rdata;
            end
         end
      end
      check({tag, "_ack_cycle"}, done ? cyc : -1, v.exp_ack);
      check({tag, "_strobes"}, strobes, v.exp_strobe);
      check({tag, "_addr_stable"}, bad, 0);
      check({tag, "_read_data"}, req_read_data, v.exp_rdata);
      check({tag, "_conflict_err"}, conflict_err, v.exp_conf);
      check({tag, "_timeout_err"}, timeout_err, v.exp_tmo);
      bad = 1'b0;
      for (int i = 0; i < v.hold; i++) begin
         @(negedge clk);
         avl_waitrequest   = 1'b1;
         avl_readdatavalid = 1'b0;
         if (req_ack || avl_read || avl_write || !req_busy) bad = 1'b1;
      end
      check({tag, "_single_ack"}, bad, 0);
      req_rreq = 1'b0;
      req_wreq = 1'b0;
      @(negedge clk);
      check({tag, "_idle_busy"}, req_busy, 0);
      check({tag, "_data_held"}, req_read_data, v.exp_rdata);
   endtask

   initial begin
      bit bad;
      //             rd wr addr          wdata         wn   dly  rdata         ack strb acc exp_rdata    hold conf tmo
      vecs[0] = mk(1, 0, 27'h0000040, 32'h0,        0,   1,   32'h1234_5678, 3,  1,   1,  32'h1234_5678, 3, 0, 0);
      vecs[1] = mk(0, 1, 27'h7FF_FFFF, 32'hCAFE_F00D, 5, 0,   32'h0,        7,  6,   1,  32'h1234_5678, 3, 0, 0);
      vecs[2] = mk(1, 0, 27'h0000123, 32'h0,        2,   0,   32'hA5A5_5A5A, 4,  3,   1,  32'hA5A5_5A5A, 1, 0, 0);
      vecs[3] = mk(1, 0, 27'h1000001, 32'h0,        0,   3,   32'h0000_0001, 5,  1,   1,  32'h0000_0001, 2, 0, 0);
      vecs[4] = mk(0, 1, 27'h0ABCDEF, 32'h0F0F_0F0F, 0,  0,   32'h0,        2,  1,   1,  32'h0000_0001, 1, 0, 0);
      vecs[5] = mk(1, 1, 27'h0000055, 32'h1111_2222, 0,  0,   32'h0,        2,  1,   1,  32'h0000_0001, 2, 1, 0);
      vecs[6] = mk(1, 0, 27'h0000066, 32'h0,        1,   2,   32'h8765_4321, 5,  2,   1,  32'h8765_4321, 1, 1, 0);
      vecs[7] = mk(1, 0, 27'h0000077, 32'h0,        0,   255, 32'h0,        9,  1,   1,  32'hDEAD_BEEF, 1, 1, 1);
      vecs[8] = mk(0, 1, 27'h0000088, 32'h3333_4444, 255, 0,  32'h0,        9,  8,   0,  32'hDEAD_BEEF, 1, 1, 1);
      post_vec = mk(1, 0, 27'h00000AB, 32'h0,       0,   1,   32'hFEED_0001, 3,  1,   1,  32'hFEED_0001, 1, 0, 0);

      repeat (2) @(negedge clk);
      check("rst_busy", req_busy, 0);
      check("rst_strobes", {avl_read, avl_write, req_ack}, 3'b000);
      check("rst_errs", {timeout_err, conflict_err}, 2'b00);
      check("rst_read_data", req_read_data, 32'h0);
      check("rst_avl_addr", avl_address, 27'h0);
      check("rst_avl_wdata", avl_writedata, 32'h0);
      check("const_be_burst", {avl_byteenable, avl_burstcount}, 7'b1111_001);
      rst = 1'b0;

      // Requests are ignored until calibration completes.
      req_address = 27'h0000300;
      req_rreq    = 1'b1;
      bad = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (avl_read || req_busy) bad = 1'b1;
      end
      check("init_gate", bad, 0);
      init_done = 1'b1;
      @(negedge clk);
      check("init_read_issue", avl_read, 1);
      check("init_read_addr", avl_address, 27'h0000300);
      avl_waitrequest   = 1'b0;
      avl_readdatavalid = 1'b1;
      avl_readdata      = 32'h0BAD_CAFE;
      @(negedge clk);
      avl_waitrequest   = 1'b1;
      avl_readdatavalid = 1'b0;
      check("init_read_ack", req_ack, 1);
      check("init_read_data", req_read_data, 32'h0BAD_CAFE);
      req_rreq = 1'b0;
      repeat (2) @(negedge clk);
      check("init_read_idle", req_busy, 0);

      for (int k = 0; k < 9; k++) run_vec(vecs[k], $sformatf("vec%0d", k));

      // Stray read data while idle is dropped.
      avl_readdatavalid = 1'b1;
      avl_readdata      = 32'h0000_0001;
      @(negedge clk);
      avl_readdatavalid = 1'b0;
      @(negedge clk);
      check("late_rdv_ignored", req_read_data, 32'hDEAD_BEEF);

      // Reset while waiting for read data.
      req_address = 27'h00000AB;
      req_rreq    = 1'b1;
      @(negedge clk);
      check("rstmid_rd_cmd", avl_read, 1);
      avl_waitrequest = 1'b0;
      @(negedge clk);
      avl_waitrequest = 1'b1;
      check("rstmid_rd_wait", {avl_read, req_busy}, 2'b01);
      rst = 1'b1;
      #1;
      check("rstmid_async_idle", {avl_read, avl_write, req_busy}, 3'b000);
      check("rstmid_errs_clear", {timeout_err, conflict_err}, 2'b00);
      check("rstmid_read_data", req_read_data, 32'h0);
      @(negedge clk);
      rst      = 1'b0;
      req_rreq = 1'b0;
      @(negedge clk);
      avl_readdatavalid = 1'b1;
      avl_readdata      = 32'h0000_0099;
      @(negedge clk);
      avl_readdatavalid = 1'b0;
      check("rstmid_late_rdv", req_read_data, 32'h0);
      check("rstmid_idle", req_busy, 0);
      run_vec(post_vec, "post_rst");

      check("scoreboard_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
